// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the RV32I fetch path.
//   fetch_state_e  - fetch sequencer state (IDLE, FETCH, DRAIN)
//   ILEN_BYTES     - instruction length in bytes, fetch_pc increment
//   DEFAULT_TRAP_VEC - default trap target address
//   fetch_entry_t  - queue entry {pc, inst}
//   align_pc()     - clears bits [1:0] of a fetch target
package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10
  } fetch_state_e;

  localparam logic [31:0] ILEN_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0010;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry synchronous queue of {pc, inst} toward decode.
//   clk, reset  - clock, asynchronous active-low reset
//   push        - write push_entry at the tail (ignored when full)
//   pop         - drop the head entry (ignored when empty)
//   flush       - empty the queue; overrides push and pop
//   count       - number of valid entries, 0..2
//   head        - entry at the head of the queue
module fetch_skid_buf
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_r [2];
  logic         rd_ptr_r;
  logic         wr_ptr_r;
  logic [1:0]   count_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign do_push_s = push && (count_r != 2'd2);
  assign do_pop_s  = pop && (count_r != 2'd0);

  // Queue storage, pointers and occupancy; flush empties but keeps stale data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I instruction-fetch sequencer.
//   clk, reset               - clock, asynchronous active-low reset
//   imem_req/addr            - request to instruction memory, held until ack
//   imem_ack/rdata           - memory accepted request, word valid this cycle
//   inst_valid/inst/inst_pc  - queue head toward decode
//   inst_ready               - decode consumes the head
//   redirect_en/redirect_pc  - jump or taken branch from execute
//   trap_en                  - trap, fetch resumes at TRAP_VEC
module fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        trap_en
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  fetch_pc_r;
  logic [31:0]  fetch_pc_nxt_s;
  logic [31:0]  saved_pc_r;
  logic [31:0]  saved_pc_nxt_s;
  logic [31:0]  target_s;
  logic         redir_s;
  logic         push_s;
  logic         pop_s;
  logic         flush_s;
  logic [1:0]   count_s;
  fetch_entry_t head_s;
  fetch_entry_t push_entry_s;

  // Trap outranks a branch/jump; both targets are word-aligned.
  assign redir_s  = trap_en | redirect_en;
  assign target_s = align_pc(trap_en ? TRAP_VEC : redirect_pc);

  assign push_entry_s = '{pc: fetch_pc_r, inst: imem_rdata};

  // Request generation: in DRAIN the old request is held regardless of the queue.
  always_comb begin
    imem_req = 1'b0;
    case (state_r)
      FETCH:   imem_req = (count_s != 2'd2);
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // A redirect flushes the queue in the same cycle, so the head is hidden from decode.
  assign inst_valid = (count_s != 2'd0) && !redir_s;
  assign pop_s      = inst_valid && inst_ready;

  // Next-state, fetch_pc and saved-target logic.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    saved_pc_nxt_s = saved_pc_r;
    push_s         = 1'b0;
    flush_s        = 1'b0;
    case (state_r)
      IDLE: begin
        state_nxt_s = FETCH;
      end
      FETCH: begin
        if (redir_s) begin
          flush_s = 1'b1;
          // An unacked request cannot be withdrawn, so wait it out in DRAIN.
          if (!imem_req || imem_ack) begin
            fetch_pc_nxt_s = target_s;
          end else begin
            saved_pc_nxt_s = target_s;
            state_nxt_s    = DRAIN;
          end
        end else if (imem_req && imem_ack) begin
          push_s         = 1'b1;
          fetch_pc_nxt_s = fetch_pc_r + ILEN_BYTES;
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
      end
      DRAIN: begin
        flush_s = redir_s;
        if (redir_s) begin
          saved_pc_nxt_s = target_s;
        end else begin
          saved_pc_nxt_s = saved_pc_r;
        end
        // Acked data belongs to the abandoned path and is discarded.
        if (imem_ack) begin
          fetch_pc_nxt_s = redir_s ? target_s : saved_pc_r;
          state_nxt_s    = FETCH;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, fetch PC and pending redirect target registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      saved_pc_r <= RESET_PC;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      saved_pc_r <= saved_pc_nxt_s;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (flush_s),
    .count      (count_s),
    .head       (head_s)
  );

  assign imem_addr = fetch_pc_r;
  assign inst      = head_s.inst;
  assign inst_pc   = head_s.pc;

endmodule
